// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for the multi-cycle ALU.
// The producer (decode) drives the master side; the ALU is the slave.
interface alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             fl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;

    modport master (
        output in_valid, opcode, A, B, cin, fl, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, opcode, A, B, cin, fl, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-step arithmetic/logic plus iterative
// one-bit-per-clock shifts and rotates, with a {C,V,N,Z,P} flag register.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int OPW   = 8
) (
    input logic       clkout,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD = OPW'(1);
    localparam logic [OPW-1:0] OP_ACA = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB = OPW'(5);
    localparam logic [OPW-1:0] OP_XNR = OPW'(9);
    localparam logic [OPW-1:0] OP_XOR = OPW'(11);
    localparam logic [OPW-1:0] OP_AND = OPW'(13);
    localparam logic [OPW-1:0] OP_ORA = OPW'(15);
    localparam logic [OPW-1:0] OP_NOT = OPW'(17);
    localparam logic [OPW-1:0] OP_NEG = OPW'(18);
    localparam logic [OPW-1:0] OP_SRL = OPW'(19);
    localparam logic [OPW-1:0] OP_SLL = OPW'(20);
    localparam logic [OPW-1:0] OP_ASR = OPW'(21);
    localparam logic [OPW-1:0] OP_ASL = OPW'(22);
    localparam logic [OPW-1:0] OP_ROR = OPW'(25);
    localparam logic [OPW-1:0] OP_ROL = OPW'(26);
    localparam logic [OPW-1:0] OP_RRC = OPW'(27);
    localparam logic [OPW-1:0] OP_RLC = OPW'(28);
    localparam logic [OPW-1:0] OP_CLR = OPW'(29);
    localparam logic [OPW-1:0] OP_INC = OPW'(30);
    localparam logic [OPW-1:0] OP_DEC = OPW'(31);

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO   = '0;
    localparam logic [SHW-1:0]   LAST   = SHW'(1);
    localparam int               MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [OPW-1:0]   op_q;
    logic             fl_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] res_q;
    logic [SHW-1:0]   cnt;
    logic             ring_c;
    logic             asl_v;
    logic [4:0]       flg_q;

    function automatic logic add_ov(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] r
    );
        return (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
    endfunction

    function automatic logic sub_ov(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] r
    );
        return (x[MSB] != y[MSB]) && (r[MSB] != x[MSB]);
    endfunction

    function automatic logic [4:0] mk_flags(
        input logic             c,
        input logic             v,
        input logic [WIDTH-1:0] r
    );
        return {c, v, r[MSB], (r == ZERO), ^r};
    endfunction

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.flags     = flg_q;

    logic             accept;
    logic [SHW-1:0]   amt;
    logic             is_iter;
    logic [WIDTH-1:0] s_res;
    logic             s_c;
    logic             s_v;
    logic             s_upd;
    logic [WIDTH:0]   ext;

    assign accept = bus.in_valid && (state == IDLE);
    assign amt    = bus.B[SHW-1:0];

    // Result of an op that completes on the accept edge
    always_comb begin
        s_res   = bus.A;
        s_c     = 1'b0;
        s_v     = 1'b0;
        s_upd   = 1'b1;
        is_iter = 1'b0;
        ext     = '0;
        unique case (bus.opcode)
            OP_ADD: begin
                ext   = {1'b0, bus.A} + {1'b0, bus.B};
                s_res = ext[MSB:0];
                s_c   = ext[WIDTH];
                s_v   = add_ov(bus.A, bus.B, s_res);
            end
            OP_ACA: begin
                ext   = {1'b0, bus.A} + {1'b0, bus.B}
                      + (WIDTH+1)'(bus.cin);
                s_res = ext[MSB:0];
                s_c   = ext[WIDTH];
                s_v   = add_ov(bus.A, bus.B, s_res);
            end
            OP_SUB: begin
                ext   = {1'b0, bus.A} - {1'b0, bus.B};
                s_res = ext[MSB:0];
                s_c   = ext[WIDTH];
                s_v   = sub_ov(bus.A, bus.B, s_res);
            end
            OP_NEG: begin
                ext   = {1'b0, ZERO} - {1'b0, bus.A};
                s_res = ext[MSB:0];
                s_c   = ext[WIDTH];
                s_v   = sub_ov(ZERO, bus.A, s_res);
            end
            OP_INC: begin
                ext   = {1'b0, bus.A} + {1'b0, ONE};
                s_res = ext[MSB:0];
                s_c   = ext[WIDTH];
                s_v   = add_ov(bus.A, ONE, s_res);
            end
            OP_DEC: begin
                ext   = {1'b0, bus.A} - {1'b0, ONE};
                s_res = ext[MSB:0];
                s_c   = ext[WIDTH];
                s_v   = sub_ov(bus.A, ONE, s_res);
            end
            OP_XNR: s_res = ~(bus.A ^ bus.B);
            OP_XOR: s_res = bus.A ^ bus.B;
            OP_AND: s_res = bus.A & bus.B;
            OP_ORA: s_res = bus.A | bus.B;
            OP_NOT: s_res = ~bus.A;
            OP_CLR: s_res = ZERO;
            OP_SRL, OP_SLL, OP_ASR, OP_ASL,
            OP_ROR, OP_ROL, OP_RRC, OP_RLC: is_iter = 1'b1;
            default: s_upd = 1'b0;
        endcase
    end

    logic [WIDTH-1:0] st_w;
    logic             st_c;
    logic             st_v;

    // One-bit step; ring_c doubles as the through-carry for RRC/RLC
    always_comb begin
        st_w = work;
        st_c = ring_c;
        st_v = asl_v;
        unique case (op_q)
            OP_SRL: begin
                st_c = work[0];
                st_w = work >> 1;
            end
            OP_SLL: begin
                st_c = work[MSB];
                st_w = work << 1;
            end
            OP_ASR: begin
                st_c = work[0];
                st_w = {work[MSB], work[MSB:1]};
            end
            OP_ASL: begin
                st_c = work[MSB];
                st_w = work << 1;
                st_v = asl_v | (work[MSB] ^ work[MSB-1]);
            end
            OP_ROR: begin
                st_c = work[0];
                st_w = {work[0], work[MSB:1]};
            end
            OP_ROL: begin
                st_c = work[MSB];
                st_w = {work[MSB-1:0], work[MSB]};
            end
            OP_RRC: begin
                st_c = work[0];
                st_w = {ring_c, work[MSB:1]};
            end
            OP_RLC: begin
                st_c = work[MSB];
                st_w = {work[MSB-1:0], ring_c};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            fl_q   <= 1'b0;
            work   <= '0;
            res_q  <= '0;
            cnt    <= '0;
            ring_c <= 1'b0;
            asl_v  <= 1'b0;
            flg_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.opcode;
                        fl_q   <= bus.fl;
                        work   <= bus.A;
                        ring_c <= bus.cin;
                        asl_v  <= 1'b0;
                        cnt    <= amt;
                        if (is_iter && amt != '0) begin
                            state <= SHIFT;
                        end else begin
                            res_q <= s_res;
                            if (bus.fl && s_upd)
                                flg_q <= mk_flags(s_c, s_v, s_res);
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work   <= st_w;
                    ring_c <= st_c;
                    asl_v  <= st_v;
                    cnt    <= cnt - LAST;
                    if (cnt == LAST) begin
                        res_q <= st_w;
                        if (fl_q)
                            flg_q <= mk_flags(st_c, st_v, st_w);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results, flags,
// latency, back-pressure and reset-abort behaviour.
module tb_alu_seq;
    logic clkout = 1'b0;
    logic rst    = 1'b1;

    always #5 clkout = ~clkout;

    alu_seq_if #(.WIDTH(32), .OPW(8)) bus ();

    alu_seq #(.WIDTH(32), .OPW(8)) dut (
        .clkout (clkout),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clkout);
        #1;
    endtask

    // Latency = clock edges after the accept edge until out_valid
    task automatic issue(
        input  logic [7:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        c,
        input  logic        f,
        output int          lat
    );
        int w;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!bus.in_ready)
            chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.opcode   = op;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = c;
        bus.fl       = f;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic take;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(
        input string       tag,
        input logic [7:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        c,
        input logic        f,
        input int          exp_lat,
        input logic [31:0] exp_res,
        input logic [4:0]  exp_flg
    );
        int lat;
        issue(op, a, b, c, f, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_flg"}, 32'(bus.flags), 32'(exp_flg));
        take();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.A         = '0;
        bus.B         = '0;
        bus.cin       = 1'b0;
        bus.fl        = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);

        // flags order {C,V,N,Z,P}
        run_op("add", 8'd1, 32'hABCD1234, 32'hBCDABCAD, 1'b0, 1'b1,
               0, 32'h68A7CEE1, 5'b11001);
        run_op("sub", 8'd5, 32'h5, 32'h5, 1'b0, 1'b1,
               0, 32'h0, 5'b00010);
        run_op("and_nofl", 8'd13, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0,
               1'b0, 0, 32'h0F000F00, 5'b00010);
        run_op("srl", 8'd19, 32'h0000000F, 32'd2, 1'b0, 1'b1,
               2, 32'h3, 5'b10000);
        run_op("rol0", 8'd26, 32'h80000000, 32'd0, 1'b0, 1'b1,
               0, 32'h80000000, 5'b00101);
        run_op("rrc", 8'd27, 32'h1, 32'd1, 1'b1, 1'b1,
               1, 32'h80000000, 5'b10101);
        run_op("asl", 8'd22, 32'h40000000, 32'd1, 1'b0, 1'b1,
               1, 32'h80000000, 5'b01101);
        run_op("asr31", 8'd21, 32'h80000000, 32'd31, 1'b0, 1'b1,
               31, 32'hFFFFFFFF, 5'b00100);
        run_op("inc", 8'd30, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b1,
               0, 32'h80000000, 5'b01101);
        run_op("unk", 8'd0, 32'h1234, 32'd0, 1'b0, 1'b1,
               0, 32'h1234, 5'b01101);
        run_op("dec", 8'd31, 32'h0, 32'd0, 1'b0, 1'b1,
               0, 32'hFFFFFFFF, 5'b10100);

        begin
            int lat;
            issue(8'd18, 32'h1, 32'd0, 1'b0, 1'b1, lat);
            chk("neg_res", bus.result, 32'hFFFFFFFF);
            chk("neg_flg", 32'(bus.flags), 32'(5'b10100));
            bus.opcode   = 8'd29;
            bus.in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("bp_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                chk("bp_res", bus.result, 32'hFFFFFFFF);
                chk("bp_flg", 32'(bus.flags), 32'(5'b10100));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk("bp_ret_ready", 32'(bus.in_ready), 32'd1);
            chk("bp_ret_valid", 32'(bus.out_valid), 32'd0);
            tick();
            chk("bp_no_accept", 32'(bus.out_valid), 32'd0);
        end

        run_op("aca", 8'd3, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1,
               0, 32'h0, 5'b10010);

        bus.opcode   = 8'd20;
        bus.A        = 32'h1;
        bus.B        = 32'd31;
        bus.fl       = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("mid_busy", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_result", bus.result, 32'd0);
        chk("mid_flags", 32'(bus.flags), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
        run_op("post_add", 8'd1, 32'h1, 32'h2, 1'b0, 1'b1,
               0, 32'h3, 5'b00000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
